// File: rtl/headbang_pkg.sv
// headbang_pkg: shared FSM state type and default timing for the headbang servo driver
package headbang_pkg;
   typedef enum logic [1:0] {IDLE, DOWN, UP, RETURN} state_t;
   localparam int DEF_PERIOD_CYCLES = 1_000_000;
   localparam int DEF_MIN_PULSE = 50_000;
   localparam int DEF_MAX_PULSE = 100_000;
   localparam int DEF_STEP = 2_500;
endpackage

// File: rtl/headbang_period_timer.sv
// headbang_period_timer: free-running PWM period counter with end-of-period tick
module headbang_period_timer import headbang_pkg::*; #(
   parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
   localparam int W = $clog2(PERIOD_CYCLES)
) (
   input  logic         clk,
   input  logic         reset,
   output logic [W-1:0] cnt_next,
   output logic         tick
);
   logic [W-1:0] cnt;
   assign tick = cnt == W'(PERIOD_CYCLES - 1);
   assign cnt_next = tick ? '0 : cnt + 1'b1;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= cnt_next;
endmodule

// File: rtl/headbang_servo_driver.sv
// headbang_servo_driver: ramps the servo PWM pulse width MIN<->MAX while enabled, homes when disabled
module headbang_servo_driver import headbang_pkg::*; #(
   parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
   parameter int MIN_PULSE = DEF_MIN_PULSE,
   parameter int MAX_PULSE = DEF_MAX_PULSE,
   parameter int STEP = DEF_STEP,
   localparam int W = $clog2(PERIOD_CYCLES)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   output logic         pwm_out,
   output logic         busy,
   output logic [W-1:0] pulse_width,
   output logic [15:0]  stroke_count
);
   if (!(0 < MIN_PULSE && MIN_PULSE < MAX_PULSE && MAX_PULSE < PERIOD_CYCLES &&
         0 < STEP && STEP <= MAX_PULSE - MIN_PULSE)) begin : g_bad_params
      $error("headbang_servo_driver: illegal timing parameters");
   end
   localparam logic [W:0] MIN_W = (W+1)'(MIN_PULSE);
   localparam logic [W:0] MAX_W = (W+1)'(MAX_PULSE);
   localparam logic [W:0] STEP_W = (W+1)'(STEP);
   state_t state, state_nxt;
   logic enable_q, tick, stroke_inc;
   logic [W-1:0] cnt_next;
   logic [W:0] pw_sum, pw_inc, pw_dec, pw_nxt;
   headbang_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
      .clk(clk), .reset(reset), .cnt_next(cnt_next), .tick(tick)
   );
   // one extra bit so MAX+STEP cannot wrap before the clamp
   assign pw_sum = {1'b0, pulse_width} + STEP_W;
   assign pw_inc = pw_sum > MAX_W ? MAX_W : pw_sum;
   assign pw_dec = {1'b0, pulse_width} < MIN_W + STEP_W ? MIN_W : {1'b0, pulse_width} - STEP_W;
   assign busy = state != IDLE;
   always_comb begin
      state_nxt = state;
      pw_nxt = {1'b0, pulse_width};
      stroke_inc = 1'b0;
      case (state)
         IDLE: state_nxt = enable_q ? DOWN : IDLE;
         DOWN: begin
            pw_nxt = pw_inc;
            state_nxt = pw_inc == MAX_W ? UP : enable_q ? DOWN : RETURN;
         end
         UP: begin
            pw_nxt = pw_dec;
            stroke_inc = pw_dec == MIN_W;
            state_nxt = stroke_inc ? (enable_q ? DOWN : IDLE) : enable_q ? UP : RETURN;
         end
         default: begin
            pw_nxt = pw_dec;
            state_nxt = enable_q ? DOWN : pw_dec == MIN_W ? IDLE : RETURN;
         end
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         enable_q <= 1'b0;
         pwm_out <= 1'b0;
         pulse_width <= W'(MIN_PULSE);
         stroke_count <= '0;
      end else begin
         enable_q <= enable;
         pwm_out <= cnt_next < pulse_width;
         if (tick) begin
            state <= state_nxt;
            pulse_width <= pw_nxt[W-1:0];
            stroke_count <= stroke_count + 16'(stroke_inc);
         end
      end
endmodule

// File: tb/tb_headbang_servo_driver.sv
// tb_headbang_servo_driver: period-by-period vector table with scoreboard, plus reset and STEP=7 sequences
module tb_headbang_servo_driver;
   localparam int P = 100;
   typedef struct { logic en; logic glitch; int pw; logic busy; int sc; } vec_t;
   typedef struct { int pw; logic busy; int sc; int hi; } exp_t;
   logic clk = 1'b0, reset = 1'b1, en5 = 1'b0, en7 = 1'b0;
   logic pwm5, busy5, pwm7, busy7;
   logic [6:0] pw5, pw7;
   logic [15:0] sc5, sc7;
   int n_cmp = 0, n_bad = 0;
   exp_t sb[$];
   vec_t t5[$], t7[$];
   always #5 clk = ~clk;
   headbang_servo_driver #(.PERIOD_CYCLES(P), .MIN_PULSE(10), .MAX_PULSE(30), .STEP(5)) dut5 (
      .clk(clk), .reset(reset), .enable(en5), .pwm_out(pwm5), .busy(busy5),
      .pulse_width(pw5), .stroke_count(sc5)
   );
   headbang_servo_driver #(.PERIOD_CYCLES(P), .MIN_PULSE(10), .MAX_PULSE(30), .STEP(7)) dut7 (
      .clk(clk), .reset(reset), .enable(en7), .pwm_out(pwm7), .busy(busy7),
      .pulse_width(pw7), .stroke_count(sc7)
   );
   function automatic vec_t mk(input logic en, input logic gl, input int pw, input logic busy, input int sc);
      mk = '{en, gl, pw, busy, sc};
   endfunction
   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask
   // one full PWM period: drive enable, queue the expected post-tick state, count pwm high cycles
   task automatic run_period(input vec_t v, input bit sel, input int prev_pw, input int row);
      exp_t e;
      int hi;
      hi = 0;
      if (sel) en7 = v.en; else en5 = v.en;
      sb.push_back('{v.pw, v.busy, v.sc, prev_pw});
      for (int c = 0; c < P; c++) begin
         @(posedge clk);
         #1;
         if (v.glitch && c == 40) en5 = 1'b1;
         if (v.glitch && c == 43) en5 = 1'b0;
         hi += int'(sel ? pwm7 : pwm5);
      end
      if (sb.size() == 0) begin
         check($sformatf("s%0d_row%0d_queue", sel, row), 0, 1);
      end else begin
         e = sb.pop_front();
         check($sformatf("s%0d_row%0d_pw", sel, row), int'(sel ? pw7 : pw5), e.pw);
         check($sformatf("s%0d_row%0d_busy", sel, row), int'(sel ? busy7 : busy5), int'(e.busy));
         check($sformatf("s%0d_row%0d_strokes", sel, row), int'(sel ? sc7 : sc5), e.sc);
         check($sformatf("s%0d_row%0d_pwm_high", sel, row), hi, e.hi);
      end
   endtask
   initial begin
      int prev;
      // idle, a short enable glitch, full strokes, drop in DOWN, drop on reaching MAX, re-enable in RETURN
      for (int i = 0; i < 3; i++) t5.push_back(mk(0, 0, 10, 0, 0));
      t5.push_back(mk(0, 1, 10, 0, 0));
      t5.push_back(mk(1, 0, 10, 1, 0));
      t5.push_back(mk(1, 0, 15, 1, 0));
      t5.push_back(mk(1, 0, 20, 1, 0));
      t5.push_back(mk(1, 0, 25, 1, 0));
      t5.push_back(mk(1, 0, 30, 1, 0));
      t5.push_back(mk(1, 0, 25, 1, 0));
      t5.push_back(mk(1, 0, 20, 1, 0));
      t5.push_back(mk(1, 0, 15, 1, 0));
      t5.push_back(mk(1, 0, 10, 1, 1));
      t5.push_back(mk(1, 0, 15, 1, 1));
      t5.push_back(mk(1, 0, 20, 1, 1));
      t5.push_back(mk(0, 0, 25, 1, 1));
      t5.push_back(mk(0, 0, 20, 1, 1));
      t5.push_back(mk(0, 0, 15, 1, 1));
      t5.push_back(mk(0, 0, 10, 0, 1));
      t5.push_back(mk(1, 0, 10, 1, 1));
      t5.push_back(mk(1, 0, 15, 1, 1));
      t5.push_back(mk(1, 0, 20, 1, 1));
      t5.push_back(mk(1, 0, 25, 1, 1));
      t5.push_back(mk(0, 0, 30, 1, 1));
      t5.push_back(mk(0, 0, 25, 1, 1));
      t5.push_back(mk(0, 0, 20, 1, 1));
      t5.push_back(mk(1, 0, 15, 1, 1));
      t5.push_back(mk(1, 0, 20, 1, 1));
      t5.push_back(mk(1, 0, 25, 1, 1));
      t5.push_back(mk(1, 0, 30, 1, 1));
      t5.push_back(mk(1, 0, 25, 1, 1));
      t5.push_back(mk(1, 0, 20, 1, 1));
      t5.push_back(mk(1, 0, 15, 1, 1));
      t5.push_back(mk(0, 0, 10, 0, 2));
      t5.push_back(mk(1, 0, 10, 1, 2));
      t5.push_back(mk(1, 0, 15, 1, 2));
      t5.push_back(mk(1, 0, 20, 1, 2));
      t5.push_back(mk(1, 0, 25, 1, 2));
      t7.push_back(mk(1, 0, 10, 1, 0));
      t7.push_back(mk(1, 0, 17, 1, 0));
      t7.push_back(mk(1, 0, 24, 1, 0));
      t7.push_back(mk(1, 0, 30, 1, 0));
      t7.push_back(mk(1, 0, 23, 1, 0));
      t7.push_back(mk(1, 0, 16, 1, 0));
      t7.push_back(mk(1, 0, 10, 1, 1));
      repeat (3) @(posedge clk);
      #1;
      check("reset_pwm", int'(pwm5), 0);
      check("reset_busy", int'(busy5), 0);
      check("reset_pw", int'(pw5), 10);
      check("reset_strokes", int'(sc5), 0);
      reset = 1'b0;
      prev = 10;
      foreach (t5[i]) begin
         run_period(t5[i], 1'b0, prev, i);
         prev = t5[i].pw;
      end
      // mid-period asynchronous reset at pw=25 while the pulse is high
      repeat (5) @(posedge clk);
      #1;
      check("pre_reset_pwm", int'(pwm5), 1);
      #2 reset = 1'b1;
      en5 = 1'b0;
      #1;
      check("async_reset_pwm", int'(pwm5), 0);
      check("async_reset_pw", int'(pw5), 10);
      check("async_reset_busy", int'(busy5), 0);
      check("async_reset_strokes", int'(sc5), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      prev = 10;
      foreach (t7[i]) begin
         run_period(t7[i], 1'b1, prev, i);
         prev = t7[i].pw;
      end
      check("dut5_still_idle_pw", int'(pw5), 10);
      check("dut5_still_idle_busy", int'(busy5), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
